// File: rtl/aes_multicycle_round_sequencer.sv
// Control sequencer for a multicycle AES-128 encryption datapath with a shared S-box bank.
// Issues load, per-round SubBytes slices and a combined ShiftRows/MixColumns/AddRoundKey step.
// Every output is a flop fed from the next-state decode, so no input reaches an output combinationally.
module aes_multicycle_round_sequencer #(
  parameter  int unsigned NUM_ROUNDS = 10,
  parameter  int unsigned SBOX_LANES = 4,
  parameter  int unsigned TRIG_ROUND = 1,
  localparam int unsigned Q          = 16 / SBOX_LANES,
  localparam int unsigned SLICE_W    = (Q > 1) ? $clog2(Q) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               load_o,
  output logic               sub_we_o,
  output logic [SLICE_W-1:0] slice_o,
  output logic               mix_o,
  output logic               mixcol_en_o,
  output logic [3:0]         rk_idx_o,
  output logic [3:0]         round_o,
  output logic               done_o,
  output logic               trig_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SUB,
    ST_MIX,
    ST_DONE
  } state_t;

  localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(Q - 1);
  localparam logic [3:0]         ROUND_LAST = 4'(NUM_ROUNDS);
  localparam logic [3:0]         ROUND_TRIG = 4'(TRIG_ROUND);

  state_t               state_q, state_d;
  logic [3:0]           round_q, round_d;
  logic [SLICE_W-1:0]   slice_q, slice_d;

  logic                 ready_d, busy_d, load_d, sub_we_d, mix_d;
  logic                 mixcol_en_d, done_d, trig_d;
  logic [SLICE_W-1:0]   slice_out_d;
  logic [3:0]           rk_idx_d, round_out_d;
  logic                 in_round_d;

  // Next-state and counter update; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    slice_d = slice_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
          round_d = '0;
          slice_d = '0;
        end
      end
      ST_LOAD: begin
        state_d = ST_SUB;
        round_d = 4'd1;
        slice_d = '0;
      end
      ST_SUB: begin
        if (slice_q == SLICE_LAST) begin
          state_d = ST_MIX;
        end else begin
          slice_d = slice_q + SLICE_W'(1);
        end
      end
      ST_MIX: begin
        if (round_q == ROUND_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SUB;
          round_d = round_q + 4'd1;
          slice_d = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        round_d = '0;
        slice_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        round_d = '0;
        slice_d = '0;
      end
    endcase
    if (abort_i) begin
      state_d = ST_IDLE;
      round_d = '0;
      slice_d = '0;
    end
  end

  // Moore decode of the upcoming state, captured into the output flops below.
  always_comb begin
    in_round_d  = (state_d == ST_SUB) || (state_d == ST_MIX);
    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d == ST_LOAD) || in_round_d;
    load_d      = (state_d == ST_LOAD);
    sub_we_d    = (state_d == ST_SUB);
    slice_out_d = (state_d == ST_SUB) ? slice_d : '0;
    mix_d       = (state_d == ST_MIX);
    mixcol_en_d = (state_d == ST_MIX) && (round_d != ROUND_LAST);
    rk_idx_d    = in_round_d ? round_d : 4'd0;
    round_out_d = in_round_d ? round_d : 4'd0;
    done_d      = (state_d == ST_DONE);
    trig_d      = in_round_d && (round_d == ROUND_TRIG);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      slice_q     <= '0;
      ready_o     <= 1'b1;
      busy_o      <= 1'b0;
      load_o      <= 1'b0;
      sub_we_o    <= 1'b0;
      slice_o     <= '0;
      mix_o       <= 1'b0;
      mixcol_en_o <= 1'b0;
      rk_idx_o    <= '0;
      round_o     <= '0;
      done_o      <= 1'b0;
      trig_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      slice_q     <= slice_d;
      ready_o     <= ready_d;
      busy_o      <= busy_d;
      load_o      <= load_d;
      sub_we_o    <= sub_we_d;
      slice_o     <= slice_out_d;
      mix_o       <= mix_d;
      mixcol_en_o <= mixcol_en_d;
      rk_idx_o    <= rk_idx_d;
      round_o     <= round_out_d;
      done_o      <= done_d;
      trig_o      <= trig_d;
    end
  end

endmodule

// File: tb/tb_aes_multicycle_round_sequencer.sv
// Scoreboard bench: four sequencer configurations, expected per-cycle outputs derived from the cycle schedule.
module tb_aes_multicycle_round_sequencer;

  localparam int N = 4;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       load;
    logic       sub;
    logic       mix;
    logic       mixcol;
    logic       done;
    logic       trig;
    logic [3:0] slice;
    logic [3:0] rk;
    logic [3:0] round;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } ev_t;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         start, abort;
  logic [N-1:0]         ready, busy, load, sub, mix, mixcol, done, trig;
  logic [N-1:0][3:0]    rk, rnd, slc;
  logic [1:0]           s0;
  logic                 s1;
  logic [3:0]           s2;
  logic                 s3;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   idle_from [N];
  ev_t  evq [N][$];

  assign slc[0] = 4'(s0);
  assign slc[1] = 4'(s1);
  assign slc[2] = s2;
  assign slc[3] = 4'(s3);

  aes_multicycle_round_sequencer u_def (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .abort_i(abort[0]),
    .ready_o(ready[0]), .busy_o(busy[0]), .load_o(load[0]), .sub_we_o(sub[0]),
    .slice_o(s0), .mix_o(mix[0]), .mixcol_en_o(mixcol[0]), .rk_idx_o(rk[0]),
    .round_o(rnd[0]), .done_o(done[0]), .trig_o(trig[0]));

  aes_multicycle_round_sequencer #(.NUM_ROUNDS(10), .SBOX_LANES(16), .TRIG_ROUND(3)) u_l16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .abort_i(abort[1]),
    .ready_o(ready[1]), .busy_o(busy[1]), .load_o(load[1]), .sub_we_o(sub[1]),
    .slice_o(s1), .mix_o(mix[1]), .mixcol_en_o(mixcol[1]), .rk_idx_o(rk[1]),
    .round_o(rnd[1]), .done_o(done[1]), .trig_o(trig[1]));

  aes_multicycle_round_sequencer #(.NUM_ROUNDS(10), .SBOX_LANES(1), .TRIG_ROUND(10)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .abort_i(abort[2]),
    .ready_o(ready[2]), .busy_o(busy[2]), .load_o(load[2]), .sub_we_o(sub[2]),
    .slice_o(s2), .mix_o(mix[2]), .mixcol_en_o(mixcol[2]), .rk_idx_o(rk[2]),
    .round_o(rnd[2]), .done_o(done[2]), .trig_o(trig[2]));

  aes_multicycle_round_sequencer #(.NUM_ROUNDS(1), .SBOX_LANES(8), .TRIG_ROUND(1)) u_r1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[3]), .abort_i(abort[3]),
    .ready_o(ready[3]), .busy_o(busy[3]), .load_o(load[3]), .sub_we_o(sub[3]),
    .slice_o(s3), .mix_o(mix[3]), .mixcol_en_o(mixcol[3]), .rk_idx_o(rk[3]),
    .round_o(rnd[3]), .done_o(done[3]), .trig_o(trig[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nr_of(int i);
    return (i == 3) ? 1 : 10;
  endfunction

  function automatic int q_of(int i);
    case (i)
      1:       return 1;
      2:       return 16;
      3:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int tr_of(int i);
    case (i)
      1:       return 3;
      2:       return 10;
      default: return 1;
    endcase
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic obs_t observe(int i);
    obs_t o;
    o.ready  = ready[i];
    o.busy   = busy[i];
    o.load   = load[i];
    o.sub    = sub[i];
    o.mix    = mix[i];
    o.mixcol = mixcol[i];
    o.done   = done[i];
    o.trig   = trig[i];
    o.slice  = slc[i];
    o.rk     = rk[i];
    o.round  = rnd[i];
    return o;
  endfunction

  // Expected schedule of one encryption whose start is seen during cycle base.
  task automatic gen(input int i, input int base);
    int nr, q, tr, last, j, r, p;
    obs_t o;
    ev_t  e;
    nr   = nr_of(i);
    q    = q_of(i);
    tr   = tr_of(i);
    last = 2 + nr * (q + 1);
    for (int k = 1; k <= last; k++) begin
      o = '0;
      if (k == 1) begin
        o.load = 1'b1;
        o.busy = 1'b1;
      end else if (k == last) begin
        o.done = 1'b1;
      end else begin
        j       = k - 2;
        r       = j / (q + 1) + 1;
        p       = j % (q + 1);
        o.busy  = 1'b1;
        o.rk    = 4'(r);
        o.round = 4'(r);
        o.trig  = (r == tr);
        if (p < q) begin
          o.sub   = 1'b1;
          o.slice = 4'(p);
        end else begin
          o.mix    = 1'b1;
          o.mixcol = (r != nr);
        end
      end
      e.cyc = base + k;
      e.o   = o;
      evq[i].push_back(e);
    end
    idle_from[i] = base + last + 1;
  endtask

  // Drive one cycle of inputs and update the reference model.
  task automatic step(input logic [N-1:0] st, input logic [N-1:0] ab);
    ev_t e;
    @(posedge clk);
    #1;
    start = st;
    abort = ab;
    for (int i = 0; i < N; i++) begin
      if (ab[i]) begin
        if (cyc < idle_from[i]) begin
          while (evq[i].size() > 0 && evq[i][$].cyc > cyc) e = evq[i].pop_back();
          idle_from[i] = cyc + 1;
        end
      end else if (st[i] && cyc >= idle_from[i]) begin
        gen(i, cyc);
      end
    end
  endtask

  task automatic check_reset(input string name);
    obs_t got;
    for (int i = 0; i < N; i++) begin
      got = observe(i);
      checks++;
      if (got !== idle_obs()) begin
        errors++;
        $display("FAIL %s inst=%0d got=%h exp=%h", name, i, got, idle_obs());
      end
    end
  endtask

  // Monitor: compare every cycle against the scoreboard head or the idle pattern.
  always @(negedge clk) begin
    obs_t got, exp;
    ev_t  e;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        while (evq[i].size() > 0 && evq[i][0].cyc < cyc) begin
          e = evq[i].pop_front();
          checks++;
          errors++;
          $display("FAIL missed_event inst=%0d cyc=%0d got=none exp=%h", i, e.cyc, e.o);
        end
        if (evq[i].size() > 0 && evq[i][0].cyc == cyc) begin
          e   = evq[i].pop_front();
          exp = e.o;
        end else begin
          exp = idle_obs();
        end
        got = observe(i);
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL outputs inst=%0d cyc=%0d got=%h exp=%h", i, cyc, got, exp);
        end
      end
    end
  end

  initial begin
    start = '0;
    abort = '0;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) idle_from[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_hold");
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) idle_from[i] = cyc;

    // Single pulse on every configuration.
    step(4'hF, 4'h0);
    repeat (179) step(4'h0, 4'h0);

    // Start held high: back-to-back operations.
    repeat (130) step(4'hF, 4'h0);
    repeat (180) step(4'h0, 4'h0);

    // Abort at cycle 20, abort-vs-start priority in idle, then restart.
    step(4'hF, 4'h0);
    repeat (19) step(4'h0, 4'h0);
    step(4'h0, 4'h1);
    repeat (9) step(4'h0, 4'h0);
    step(4'hB, 4'h2);
    repeat (5) step(4'h0, 4'h0);
    step(4'h1, 4'h0);
    repeat (200) step(4'h0, 4'h0);

    // Randomized starts and aborts.
    for (int c = 0; c < 1500; c++) begin
      logic [N-1:0] st, ab;
      for (int i = 0; i < N; i++) begin
        st[i] = ($urandom_range(0, 7) == 0);
        ab[i] = ($urandom_range(0, 63) == 0);
      end
      step(st, ab);
    end
    repeat (200) step(4'h0, 4'h0);

    // Asynchronous reset in round 5 of the default configuration.
    step(4'hF, 4'h0);
    repeat (24) step(4'h0, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    for (int i = 0; i < N; i++) evq[i].delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) idle_from[i] = cyc;
    repeat (200) step(4'h0, 4'h0);

    for (int i = 0; i < N; i++) begin
      checks++;
      if (evq[i].size() != 0) begin
        errors++;
        $display("FAIL leftover_events inst=%0d got=%0d exp=0", i, evq[i].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
